// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB types, unit indices and index helpers for the CDB arbiter slice.
// Tag/data widths and the invalid tag come from common_def.h; these are fallbacks when it is absent.
`ifndef INST_TAG_WIDTH
`define INST_TAG_WIDTH 6
`endif
`ifndef COMMON_WIDTH
`define COMMON_WIDTH 32
`endif
`ifndef TAG_INVALID
`define TAG_INVALID {`INST_TAG_WIDTH{1'b1}}
`endif

package cdb_arbiter_pkg;

  localparam int CDB_TAG_W  = `INST_TAG_WIDTH;
  localparam int CDB_DATA_W = `COMMON_WIDTH;

  localparam logic [1:0] CDB_SRC_ALU = 2'd0;
  localparam logic [1:0] CDB_SRC_LSU = 2'd1;
  localparam logic [1:0] CDB_SRC_BR  = 2'd2;

  localparam logic [CDB_TAG_W-1:0] CDB_TAG_INVALID = `TAG_INVALID;

  typedef struct packed {
    logic [CDB_TAG_W-1:0]  tag;
    logic [CDB_DATA_W-1:0] data;
  } cdb_entry_t;

  // Increment with wrap at an arbitrary (not necessarily power-of-two) modulus.
  function automatic int wrap_inc(input int value, input int modulus);
    return (value + 32'sd1 >= modulus) ? 32'sd0 : value + 32'sd1;
  endfunction

  // Round-robin scan position: base + offset folded back into [0, modulus).
  function automatic int rr_index(input int base, input int offset, input int modulus);
    int raw;
    raw = base + offset;
    return (raw >= modulus) ? raw - modulus : raw;
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-unit result FIFO: circular buffer of {tag, data} with registered occupancy.
// Pushes are only honoured when space exists; pops only when non-empty.
module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [TAG_W-1:0]                 push_tag,
  input  logic [DATA_W-1:0]                push_data,
  input  logic                             pop,
  output logic [TAG_W-1:0]                 head_tag,
  output logic [DATA_W-1:0]                head_data,
  output logic [$clog2(DEPTH + 1)-1:0]     count,
  output logic                             ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [TAG_W-1:0]  mem_tag_r  [DEPTH];
  logic [DATA_W-1:0] mem_data_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign ready     = (count_r < CNT_W'(DEPTH));
  assign count     = count_r;
  assign head_tag  = mem_tag_r[rd_ptr_r];
  assign head_data = mem_data_r[rd_ptr_r];

  // Qualify handshakes against registered occupancy so a same-cycle pop never frees space early.
  always_comb begin
    do_push_s = push && ready;
    do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
  end

  // Pointer and occupancy update; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= PTR_W'(wrap_inc(int'(wr_ptr_r), DEPTH));
      end
      if (do_pop_s) begin
        rd_ptr_r <= PTR_W'(wrap_inc(int'(rd_ptr_r), DEPTH));
      end
      if (do_push_s && !do_pop_s) begin
        count_r <= count_r + CNT_W'(1);
      end else if (!do_push_s && do_pop_s) begin
        count_r <= count_r - CNT_W'(1);
      end
    end
  end

  // Entry storage, cleared on reset so the head never shows stale results.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_tag_r[i]  <= {TAG_W{1'b0}};
        mem_data_r[i] <= {DATA_W{1'b0}};
      end
    end else if (do_push_s) begin
      mem_tag_r[wr_ptr_r]  <= push_tag;
      mem_data_r[wr_ptr_r] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one FIFO per functional unit, round-robin grant of one
// FIFO head per cycle into a registered broadcast stage backpressured by the ROB.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = CDB_TAG_W,
  parameter int DATA_W = CDB_DATA_W,
  localparam int SRC_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*TAG_W-1:0]    req_tag,
  input  logic [N_REQ*DATA_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  input  logic                      cdb_ready,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [TAG_W-1:0] TAG_INV_C = TAG_W'(`TAG_INVALID);

  logic [N_REQ-1:0]             push_s;
  logic [N_REQ-1:0]             pop_s;
  logic [N_REQ-1:0]             fifo_ready_s;
  logic [N_REQ-1:0]             nonempty_s;
  logic [N_REQ-1:0][TAG_W-1:0]  head_tag_s;
  logic [N_REQ-1:0][DATA_W-1:0] head_data_s;
  logic [N_REQ-1:0][CNT_W-1:0]  count_s;

  logic              load_s;
  logic              found_s;
  logic [SRC_W-1:0]  winner_s;
  logic [TAG_W-1:0]  sel_tag_s;
  logic [DATA_W-1:0] sel_data_s;

  logic              cdb_valid_r;
  logic [TAG_W-1:0]  cdb_tag_r;
  logic [DATA_W-1:0] cdb_data_r;
  logic [SRC_W-1:0]  cdb_src_r;
  logic [SRC_W-1:0]  rr_ptr_r;

  for (genvar g = 0; g < N_REQ; g++) begin : g_fifo
    cdb_req_fifo #(
      .DEPTH  (DEPTH),
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_s[g]),
      .push_tag  (req_tag[g*TAG_W +: TAG_W]),
      .push_data (req_data[g*DATA_W +: DATA_W]),
      .pop       (pop_s[g]),
      .head_tag  (head_tag_s[g]),
      .head_data (head_data_s[g]),
      .count     (count_s[g]),
      .ready     (fifo_ready_s[g])
    );
  end

  assign req_ready = fifo_ready_s;
  assign cdb_valid = cdb_valid_r;
  assign cdb_tag   = cdb_tag_r;
  assign cdb_data  = cdb_data_r;
  assign cdb_src   = cdb_src_r;

  // Invalid-tag pushes complete the handshake but are never written into a FIFO.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      nonempty_s[i] = (count_s[i] != {CNT_W{1'b0}});
      push_s[i]     = req_valid[i] && fifo_ready_s[i] &&
                      (req_tag[i*TAG_W +: TAG_W] != TAG_INV_C);
    end
  end

  // Round-robin scan: first non-empty FIFO at or after rr_ptr, wrapping at N_REQ.
  always_comb begin
    int idx;
    idx        = 0;
    found_s    = 1'b0;
    winner_s   = rr_ptr_r;
    sel_tag_s  = cdb_tag_r;
    sel_data_s = cdb_data_r;
    for (int k = 0; k < N_REQ; k++) begin
      idx = rr_index(int'(rr_ptr_r), k, N_REQ);
      if (!found_s && nonempty_s[idx]) begin
        found_s    = 1'b1;
        winner_s   = SRC_W'(idx);
        sel_tag_s  = head_tag_s[idx];
        sel_data_s = head_data_s[idx];
      end else begin
        found_s    = found_s;
      end
    end
  end

  // The output stage accepts a new head whenever it is empty or the ROB takes the current one.
  always_comb begin
    load_s = !cdb_valid_r || cdb_ready;
    for (int i = 0; i < N_REQ; i++) begin
      pop_s[i] = load_s && found_s && (winner_s == SRC_W'(i));
    end
  end

  // Broadcast register; an empty load only drops valid, tag/data/src/rr_ptr keep their values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= TAG_INV_C;
      cdb_data_r  <= {DATA_W{1'b0}};
      cdb_src_r   <= {SRC_W{1'b0}};
      rr_ptr_r    <= {SRC_W{1'b0}};
    end else if (load_s) begin
      if (found_s) begin
        cdb_valid_r <= 1'b1;
        cdb_tag_r   <= sel_tag_s;
        cdb_data_r  <= sel_data_s;
        cdb_src_r   <= winner_s;
        rr_ptr_r    <= SRC_W'(wrap_inc(int'(winner_s), N_REQ));
      end else begin
        cdb_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based model of the push / round-robin / broadcast rules.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N     = 3;
  localparam int DEPTH = 2;
  localparam int TW    = CDB_TAG_W;
  localparam int DW    = CDB_DATA_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*TW-1:0] req_tag;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_ready;
  logic            cdb_valid;
  logic [TW-1:0]   cdb_tag;
  logic [DW-1:0]   cdb_data;
  logic [1:0]      cdb_src;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: one queue per unit plus the broadcast stage state.
  cdb_entry_t    mq [N][$];
  logic          m_valid;
  logic [TW-1:0] m_tag;
  logic [DW-1:0] m_data;
  logic [1:0]    m_src;
  int            m_rr;

  cdb_arbiter #(.N_REQ(N), .DEPTH(DEPTH), .TAG_W(TW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb_ready (cdb_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    for (int i = 0; i < N; i++) mq[i].delete();
    m_valid = 1'b0;
    m_tag   = CDB_TAG_INVALID;
    m_data  = '0;
    m_src   = 2'd0;
    m_rr    = 0;
  endtask

  // Apply the rules for one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit         acc [N];
    cdb_entry_t e;
    int         w;
    int         j;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) acc[i] = req_valid[i] && (mq[i].size() < DEPTH);
    if (!m_valid || cdb_ready) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_rr + k) % N;
        if (w < 0 && mq[j].size() > 0) w = j;
      end
      if (w >= 0) begin
        e       = mq[w].pop_front();
        m_valid = 1'b1;
        m_tag   = e.tag;
        m_data  = e.data;
        m_src   = 2'(w);
        m_rr    = (w + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (acc[i] && req_tag[i*TW +: TW] != CDB_TAG_INVALID) begin
        e.tag  = req_tag[i*TW +: TW];
        e.data = req_data[i*DW +: DW];
        mq[i].push_back(e);
      end
    end
  endtask

  function automatic logic [N-1:0] model_ready();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = (mq[i].size() < DEPTH);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_idle();
    req_valid = '0;
    req_tag   = '0;
    req_data  = '0;
  endtask

  task automatic put(input int i, input logic [TW-1:0] t, input logic [DW-1:0] d);
    req_valid[i]         = 1'b1;
    req_tag[i*TW +: TW]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cdb_ready = 1'b1;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cdb_valid);
    if (cdb_valid !== 1'b0) n_fail++;
    tick();
    n_tests++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid: got %b expected 0", cdb_valid); end
    n_tests++; if (cdb_tag !== CDB_TAG_INVALID) begin n_fail++; $display("FAIL reset_tag: got %h expected %h", cdb_tag, CDB_TAG_INVALID); end
    n_tests++; if (cdb_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", cdb_data); end
    n_tests++; if (cdb_src !== 2'd0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", cdb_src); end
    n_tests++; if (req_ready !== 3'b111) begin n_fail++; $display("FAIL reset_ready: got %b expected 111", req_ready); end
  endtask

  task automatic test_single_alu();
    do_reset();
    put(0, TW'(1), 32'h0000_00AA);
    n_tests++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL alu_ready: got %b expected 1", req_ready[0]); end
    tick();
    set_idle();
    n_tests++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_early: got valid %b expected 0", cdb_valid); end
    tick();
    n_tests++;
    if (cdb_valid !== 1'b1 || cdb_tag !== TW'(1) || cdb_data !== 32'h0000_00AA || cdb_src !== CDB_SRC_ALU) begin
      n_fail++;
      $display("FAIL alu_bcast: got v=%b tag=%h data=%h src=%0d expected v=1 tag=01 data=000000aa src=0",
               cdb_valid, cdb_tag, cdb_data, cdb_src);
    end
    tick();
    n_tests++; if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL alu_drop: got valid %b expected 0", cdb_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < N; i++) put(i, TW'(3*s + i + 1), DW'(32'h100 + 3*s + i + 1));
      tick();
      set_idle();
      for (int k = 0; k < N; k++) begin
        tick();
        n_tests++;
        if (cdb_valid !== 1'b1 || cdb_tag !== TW'(3*s + k + 1) || cdb_src !== 2'(k) ||
            cdb_data !== DW'(32'h100 + 3*s + k + 1)) begin
          n_fail++;
          $display("FAIL rr_order set%0d slot%0d: got v=%b tag=%0d src=%0d data=%h expected v=1 tag=%0d src=%0d",
                   s, k, cdb_valid, cdb_tag, cdb_src, cdb_data, 3*s + k + 1, k);
        end
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    logic [TW-1:0] seen [$];
    int next_tag;
    do_reset();
    next_tag = 7;
    for (int c = 0; c < 14; c++) begin
      set_idle();
      cdb_ready = (c >= 5);
      if (next_tag <= 10) put(1, TW'(next_tag), DW'(32'h700 + next_tag));
      n_tests++;
      if (req_ready !== model_ready()) begin
        n_fail++; $display("FAIL bp_ready c%0d: got %b expected %b", c, req_ready, model_ready());
      end
      n_tests++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {m_valid, m_tag, m_data, m_src}) begin
        n_fail++;
        $display("FAIL bp_out c%0d: got v=%b tag=%h data=%h src=%0d expected v=%b tag=%h data=%h src=%0d",
                 c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
      end
      if (c < 5 && cdb_valid) begin
        n_tests++;
        if (cdb_tag !== TW'(7)) begin n_fail++; $display("FAIL bp_hold c%0d: got tag %0d expected 7", c, cdb_tag); end
      end
      if (c == 3 || c == 4) begin
        n_tests++;
        if (req_ready[1] !== 1'b0) begin n_fail++; $display("FAIL bp_full c%0d: got %b expected 0", c, req_ready[1]); end
      end
      if (cdb_valid && cdb_ready) seen.push_back(cdb_tag);
      if (next_tag <= 10 && mq[1].size() < DEPTH) next_tag++;
      tick();
    end
    n_tests++;
    if (seen.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d broadcasts expected 4", seen.size()); end
    for (int k = 0; k < 4 && k < seen.size(); k++) begin
      n_tests++;
      if (seen[k] !== TW'(7 + k)) begin n_fail++; $display("FAIL bp_seq%0d: got %0d expected %0d", k, seen[k], 7 + k); end
    end
  endtask

  task automatic test_invalid_tag();
    do_reset();
    put(0, CDB_TAG_INVALID, 32'hDEAD_BEEF);
    n_tests++; if (req_ready[0] !== 1'b1) begin n_fail++; $display("FAIL inv_hs: got %b expected 1", req_ready[0]); end
    tick();
    set_idle();
    for (int c = 0; c < 4; c++) begin
      n_tests++;
      if (cdb_valid !== 1'b0 || req_ready !== 3'b111) begin
        n_fail++; $display("FAIL inv_discard c%0d: got v=%b ready=%b expected v=0 ready=111", c, cdb_valid, req_ready);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cdb_ready = 1'b0;
    put(0, TW'(11), 32'h11);
    put(1, TW'(12), 32'h12);
    tick();
    set_idle();
    put(0, TW'(13), 32'h13);
    tick();
    set_idle();
    n_tests++;
    if (cdb_valid !== 1'b1 || cdb_tag !== TW'(11)) begin
      n_fail++; $display("FAIL mid_held: got v=%b tag=%0d expected v=1 tag=11", cdb_valid, cdb_tag);
    end
    rst = 1'b1;
    cdb_ready = 1'b1;
    put(2, TW'(14), 32'h14);
    tick();
    rst = 1'b0;
    set_idle();
    n_tests++;
    if (cdb_valid !== 1'b0 || cdb_tag !== CDB_TAG_INVALID || cdb_data !== 32'h0 || cdb_src !== 2'd0 || req_ready !== 3'b111) begin
      n_fail++;
      $display("FAIL mid_reset: got v=%b tag=%h data=%h src=%0d ready=%b expected v=0 tag=%h data=0 src=0 ready=111",
               cdb_valid, cdb_tag, cdb_data, cdb_src, req_ready, CDB_TAG_INVALID);
    end
    for (int c = 0; c < 6; c++) begin
      tick();
      n_tests++;
      if (cdb_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale c%0d: got v=%b tag=%0d expected v=0", c, cdb_valid, cdb_tag); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      set_idle();
      rst = ($urandom_range(0, 99) == 0);
      cdb_ready = (c % 50 < 12) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 9) < 6) begin
          if ($urandom_range(0, 15) == 0) put(i, CDB_TAG_INVALID, DW'($urandom));
          else put(i, TW'($urandom_range(1, (1 << TW) - 2)), DW'($urandom));
        end
      end
      n_tests++;
      if (req_ready !== model_ready()) begin
        n_fail++; $display("FAIL rnd_ready c%0d: got %b expected %b", c, req_ready, model_ready());
      end
      n_tests++;
      if ({cdb_valid, cdb_tag, cdb_data, cdb_src} !== {m_valid, m_tag, m_data, m_src}) begin
        n_fail++;
        $display("FAIL rnd_out c%0d: got v=%b tag=%h data=%h src=%0d expected v=%b tag=%h data=%h src=%0d",
                 c, cdb_valid, cdb_tag, cdb_data, cdb_src, m_valid, m_tag, m_data, m_src);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cdb_ready = 1'b1;
    set_idle();
    model_reset();
    test_reset();
    test_single_alu();
    test_round_robin();
    test_back_to_back_stall();
    test_invalid_tag();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
